// File: rtl/wisc_pkg.sv
// Shared types and opcode constants for the WISC multicycle control path.
// Imported by the opcode classifier and the control FSM.
package wisc_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_LBI  = 5'b11000;

    // Jumps are 001xx, conditional branches are 011xx.
    localparam logic [2:0] OP_JMP_PREFIX = 3'b001;
    localparam logic [2:0] OP_BR_PREFIX  = 3'b011;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wb_sel_t;

    typedef struct packed {
        logic    writes_reg;
        wb_sel_t wb_sel;
        logic    is_mem;
        logic    is_store;
        logic    is_jump;
        logic    is_branch;
        logic    is_halt;
        logic    is_nop;
    } op_class_t;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational classification of a 5-bit WISC opcode into the attributes
// the control FSM branches on.
module opcode_class
    import wisc_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  cls
);

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        cls            = '0;
        cls.wb_sel     = WB_ALU;
        cls.is_halt    = (opcode == OP_HALT);
        cls.is_nop     = (opcode == OP_NOP);
        cls.is_jump    = (opcode[4:2] == OP_JMP_PREFIX);
        cls.is_branch  = (opcode[4:2] == OP_BR_PREFIX);
        cls.is_store   = (opcode == OP_ST) || (opcode == OP_STU);
        cls.is_mem     = (opcode == OP_ST) || (opcode == OP_STU) || (opcode == OP_LD);

        casez (opcode)
            5'b010??, 5'b101??, 5'b11???, OP_SLBI, OP_STU: cls.writes_reg = 1'b1;
            OP_LD: begin
                cls.writes_reg = 1'b1;
                cls.wb_sel     = WB_MEM;
            end
            OP_JAL, OP_JALR: begin
                cls.writes_reg = 1'b1;
                cls.wb_sel     = WB_LINK;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch / decode / execute / memory / writeback over a
// shared ready-handshaked memory, with sticky halt and memory time-out states.
module multicycle_ctrl
    import wisc_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic       br_taken,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       ir_en,
    output logic       pc_en,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       err
);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                wait_expired;
    op_class_t           cls;

    opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

    // The current cycle is wait-cycle wait_cnt+1; the last allowed one is MAX_WAIT.
    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1)) && !mem_rdy;

    // NOTE: state is updated with non-blocking assignments only; all decode is in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        halted    = 1'b0;
        err       = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_en     = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (cls.is_halt)     state_nxt = S_HALT;
                else if (cls.is_nop) state_nxt = S_FETCH;
                else                 state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cls.is_jump || (cls.is_branch && br_taken)) begin
                    pc_en  = 1'b1;
                    pc_src = 1'b1;
                end
                if (cls.is_mem)          state_nxt = S_MEM;
                else if (cls.writes_reg) state_nxt = S_WB;
                else                     state_nxt = S_FETCH;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_wr  = cls.is_store;
                if (mem_rdy) begin
                    state_nxt = cls.writes_reg ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = cls.wb_sel;
                state_nxt = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_ERR:  err    = 1'b1;
            default: state_nxt = S_FETCH;
        endcase

        // NOTE: outputs are forced low while reset is held so no strobe (e.g. a WB write) survives it.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
            ir_en     = 1'b0;
            pc_en     = 1'b0;
            pc_src    = 1'b0;
            reg_write = 1'b0;
            wb_sel    = WB_ALU;
            halted    = 1'b0;
            err       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency table, hand-written corner
// sequences and randomized instructions against a phase-level reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = '0;
    logic       br_taken = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_req, mem_wr, ir_en, pc_en, pc_src, reg_write, halted, err;
    logic [1:0] wb_sel;

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .mem_rdy   (mem_rdy),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       ir_en;
        logic       pc_en;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       halted;
        logic       err;
    } outs_t;

    // rdy: 0/1 = value that must be driven, 2 = don't care (randomized)
    typedef struct {
        int    rdy;
        outs_t exp;
        int    phase;
    } step_t;

    typedef struct {
        logic [4:0] op;
        logic       br;
        int         lat;
        logic       rw;
        logic [1:0] sel;
        logic       src;
        logic       wr;
    } vec_t;

    int    total = 0;
    int    bad = 0;
    step_t trace[$];
    vec_t  vecs[14];

    function automatic outs_t cur();
        return {mem_req, mem_wr, ir_en, pc_en, pc_src, reg_write, wb_sel, halted, err};
    endfunction

    function automatic outs_t mk(bit req, bit wr, bit ir, bit pc, bit src, bit rw,
                                 logic [1:0] sel, bit h, bit e);
        return {req, wr, ir, pc, src, rw, sel, h, e};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input outs_t got, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (req wr ir pc src rw sel[2] halt err)",
                     name, got, exp);
        end
    endtask

    // Instruction classes taken straight from the opcode lists.
    function automatic bit m_writes(logic [4:0] op);
        return (op >= 5'd8 && op <= 5'd11) || (op >= 5'd20) || op == 5'd17 ||
               op == 5'd18 || op == 5'd19 || op == 5'd6 || op == 5'd7;
    endfunction

    function automatic logic [1:0] m_sel(logic [4:0] op);
        if (op == 5'd17) return 2'b01;
        if (op == 5'd6 || op == 5'd7) return 2'b10;
        return 2'b00;
    endfunction

    // Expected per-cycle trace of one instruction: fw/mw = idle cycles before mem_rdy.
    task automatic build(input logic [4:0] op, input bit br, input int fw, input int mw);
        bit is_mem, is_st, redirect;
        is_mem   = (op == 5'd16 || op == 5'd17 || op == 5'd19);
        is_st    = (op == 5'd16 || op == 5'd19);
        redirect = (op >= 5'd4 && op <= 5'd7) || (op >= 5'd12 && op <= 5'd15 && br);
        for (int i = 0; i < fw; i++) trace.push_back('{0, mk(1,0,0,0,0,0,2'b00,0,0), 1});
        trace.push_back('{1, mk(1,0,1,1,0,0,2'b00,0,0), 1});
        trace.push_back('{2, mk(0,0,0,0,0,0,2'b00,0,0), 2});
        if (op == 5'd0) begin
            for (int i = 0; i < 4; i++) trace.push_back('{2, mk(0,0,0,0,0,0,2'b00,1,0), 6});
            return;
        end
        if (op == 5'd1) return;
        trace.push_back('{2, mk(0,0,0,redirect,redirect,0,2'b00,0,0), 3});
        if (is_mem) begin
            for (int i = 0; i < mw; i++) trace.push_back('{0, mk(1,is_st,0,0,0,0,2'b00,0,0), 4});
            trace.push_back('{1, mk(1,is_st,0,0,0,0,2'b00,0,0), 4});
        end
        if (m_writes(op)) trace.push_back('{2, mk(0,0,0,0,0,1,m_sel(op),0,0), 5});
    endtask

    task automatic run_trace(input string tag);
        step_t e;
        while (trace.size() > 0) begin
            e = trace.pop_front();
            mem_rdy = (e.rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(e.rdy);
            #1;
            check_outs($sformatf("%s op=%0d phase=%0d", tag, opcode, e.phase), cur(), e.exp);
            @(negedge clk);
        end
    endtask

    // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outs("reset outputs", cur(), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         lat;
        logic       rw_any, src_any, wr_any;
        logic [1:0] sel_seen;
        lat = -1; rw_any = 0; src_any = 0; wr_any = 0; sel_seen = 2'b00;
        opcode = v.op; br_taken = v.br; mem_rdy = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            #1;
            if (cyc > 1 && ir_en) begin
                lat = cyc - 1;
                break;
            end
            rw_any  |= reg_write;
            src_any |= pc_src;
            wr_any  |= mem_wr;
            if (reg_write) sel_seen = wb_sel;
            @(negedge clk);
        end
        check($sformatf("vec%0d op=%0d latency", idx, v.op), lat, v.lat);
        check($sformatf("vec%0d op=%0d reg_write", idx, v.op), int'(rw_any), int'(v.rw));
        check($sformatf("vec%0d op=%0d wb_sel", idx, v.op), int'(sel_seen), int'(v.sel));
        check($sformatf("vec%0d op=%0d pc_src", idx, v.op), int'(src_any), int'(v.src));
        check($sformatf("vec%0d op=%0d mem_wr", idx, v.op), int'(wr_any), int'(v.wr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op        br lat rw sel    src wr
        vecs[0]  = '{5'b01000, 0, 4, 1, 2'b00, 0, 0};  // ADDI
        vecs[1]  = '{5'b10001, 0, 5, 1, 2'b01, 0, 0};  // LD
        vecs[2]  = '{5'b10000, 0, 4, 0, 2'b00, 0, 1};  // ST
        vecs[3]  = '{5'b10011, 0, 5, 1, 2'b00, 0, 1};  // STU
        vecs[4]  = '{5'b01100, 1, 3, 0, 2'b00, 1, 0};  // BEQZ taken
        vecs[5]  = '{5'b01100, 0, 3, 0, 2'b00, 0, 0};  // BEQZ not taken
        vecs[6]  = '{5'b00100, 0, 3, 0, 2'b00, 1, 0};  // J
        vecs[7]  = '{5'b00110, 0, 4, 1, 2'b10, 1, 0};  // JAL
        vecs[8]  = '{5'b00111, 1, 4, 1, 2'b10, 1, 0};  // JALR
        vecs[9]  = '{5'b00001, 0, 2, 0, 2'b00, 0, 0};  // NOP
        vecs[10] = '{5'b11000, 0, 4, 1, 2'b00, 0, 0};  // LBI
        vecs[11] = '{5'b10010, 0, 4, 1, 2'b00, 0, 0};  // SLBI
        vecs[12] = '{5'b00010, 1, 3, 0, 2'b00, 0, 0};  // unlisted
        vecs[13] = '{5'b11010, 0, 4, 1, 2'b00, 0, 0};  // ALU reg-reg

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i], i);

        // ADDI cycle by cycle with memory always ready.
        do_reset();
        opcode = 5'b01000; mem_rdy = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("addi reg_write c%0d", c), int'(reg_write), int'(c == 4));
            if (c == 4) check("addi wb_sel", int'(wb_sel), 0);
            if (c == 5) check("addi next mem_req", int'(mem_req), 1);
            @(negedge clk);
        end

        // LD with data ready after 3 idle cycles, then ready on fetch wait-cycle 15.
        do_reset();
        opcode = 5'b10001; br_taken = 1'b0;
        build(5'b10001, 0, 0, 3);
        run_trace("ld delayed");
        opcode = 5'b01000;
        build(5'b01000, 0, 14, 0);
        run_trace("fetch rdy on wait 15");

        // Fetch time-out: error on cycle 16, sticky, ready ignored afterwards.
        do_reset();
        mem_rdy = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            mem_rdy = (c > 16);
            #1;
            check($sformatf("fetch timeout c%0d", c), int'({mem_req, ir_en, err, halted}),
                  (c <= 15) ? 4'b1000 : 4'b0010);
            @(negedge clk);
        end

        // Data-memory time-out after 15 MEM cycles.
        do_reset();
        opcode = 5'b10000; mem_rdy = 1'b1;
        repeat (3) @(negedge clk);
        mem_rdy = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            #1;
            check($sformatf("mem timeout c%0d", c), int'({mem_req, mem_wr, err}),
                  (c <= 15) ? 3'b110 : 3'b001);
            @(negedge clk);
        end

        // HALT: halted from the cycle after DECODE, no more memory requests.
        do_reset();
        opcode = 5'b00000;
        build(5'b00000, 0, 1, 0);
        run_trace("halt");
        mem_rdy = 1'b1; opcode = 5'b01000;
        #1;
        check("halt held", int'({halted, mem_req}), 2'b10);
        @(negedge clk);

        // Reset asserted in the WB cycle cancels the write at once.
        do_reset();
        opcode = 5'b01000; mem_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("wb before reset", int'(reg_write), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("wb reset drops", cur(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fetch after wb reset", int'({mem_req, ir_en, reg_write}), 3'b110);
        @(negedge clk);

        // Randomized instruction stream against the reference model.
        do_reset();
        for (int n = 0; n < 120; n++) begin
            logic [4:0] op;
            int fw, mw;
            op = 5'($urandom_range(1, 31));
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            opcode = op;
            br_taken = 1'($urandom_range(0, 1));
            build(op, br_taken, fw, mw);
            run_trace("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the WISC 5-bit-opcode processor. Sequences instruction fetch, decode, execute, data-memory access and register writeback over a shared single-port memory with a ready handshake. Owns the register-file write enable, write-data select and PC/IR load strobes, and detects halt and memory time-outs. Sits between the instruction register and the datapath enables.

## Interface
- `MAX_WAIT`, 15: cycles a memory request may wait for `mem_rdy` before error.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  5  IR[15:11], valid from DECODE onward
- `br_taken`  in  1  branch condition from ALU, sampled in EXEC
- `mem_rdy`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request (fetch or data)
- `mem_wr`  out  1  data write qualifier, valid with `mem_req`
- `ir_en`  out  1  load IR
- `pc_en`  out  1  load PC
- `pc_src`  out  1  0 = PC+2, 1 = branch/jump target
- `reg_write`  out  1  register-file write enable
- `wb_sel`  out  2  00 ALU, 01 memory data, 10 PC+2 link
- `halted`  out  1  sticky, HALT executed
- `err`  out  1  sticky, memory time-out

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- FETCH: `mem_req`=1, `mem_wr`=0. On `mem_rdy`: `ir_en`=1, `pc_en`=1, `pc_src`=0, go DECODE.
- DECODE: 00000 (HALT) -> HALT; 00001 (NOP) -> FETCH; otherwise -> EXEC.
- EXEC, one cycle:
  - Jumps 00100-00111 assert `pc_en`, `pc_src`=1.
  - Branches 011xx assert `pc_en`, `pc_src`=1 only if `br_taken`.
  - 10000 ST, 10001 LD, 10011 STU -> MEM.
  - Writeback class -> WB.
  - All others -> FETCH.
- Writeback class: 01000-01011, 10100-10111, 11001, 11011, 11010, 11100-11111 (`wb_sel`=00); 11000 LBI, 10010 SLBI (00); 00110 JAL, 00111 JALR (10). STU writes base via ALU (00); LD uses 01.
- MEM: `mem_req`=1, `mem_wr`=1 for ST/STU. On `mem_rdy`, LD/STU -> WB, ST -> FETCH.
- WB: `reg_write`=1 for exactly one cycle, `wb_sel` per class, -> FETCH.
- HALT: `halted`=1, all strobes 0, held until reset.
- ERR: `err`=1, all strobes 0, held until reset.
- Unlisted opcodes behave as NOP after EXEC: no write, -> FETCH.

## Timing
- Reset (async, `rst_n`=0): state FETCH, wait counter 0, every output 0 (`halted`=`err`=0). First `mem_req` is in the first cycle after deassertion.
- All outputs are Moore/registered-state decoded. No output depends combinationally on `mem_rdy`, except that `ir_en`/`pc_en` in FETCH and the MEM exit qualify with `mem_rdy` in the same cycle.
- Minimum latency, `mem_rdy` tied high:
  - ALU op: 4 cycles (F, D, E, WB).
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
- Wait counter: 4 bits, cleared on entering FETCH/MEM and on `mem_rdy`. Increments each waiting cycle. If it reaches `MAX_WAIT` with `mem_rdy` still 0, go ERR next cycle. `mem_rdy` on the `MAX_WAIT` cycle completes normally.
- `mem_rdy` outside FETCH/MEM is ignored.
- `reg_write` and `pc_en` are never both high, except JAL/JALR: PC loads in EXEC, link writes in WB. `wb_sel`=10 therefore needs the datapath to hold the old PC+2.
- Reset asserted mid-WB cancels the write immediately.

## Structure
- Shared package `wisc_pkg`: state enum, opcode localparams (HALT, NOP, ST, LD, STU, LBI, SLBI, J, JR, JAL, JALR, branch prefix 011), `wb_sel` encodings.
- One sub-module, `opcode_class`: combinational decode of `opcode` to {writes_reg, wb_sel, is_mem, is_store, is_jump, is_branch, is_halt, is_nop}. The FSM and counter live in `multicycle_ctrl`.

## Test plan
- ADDI (01000), `mem_rdy`=1: `reg_write`=1 only in cycle 4, `wb_sel`=00, then `mem_req`=1 in cycle 5.
- LD (10001), data `mem_rdy` delayed 3 cycles: MEM held 4 cycles, then WB with `wb_sel`=01. No `mem_wr`.
- BEQZ (01100), `br_taken`=1 vs 0: `pc_en`, `pc_src`=1 in EXEC only when taken; `reg_write` never asserted.
- JAL (00110): `pc_src`=1 in EXEC, then `reg_write`=1 with `wb_sel`=10 next cycle.
- `MAX_WAIT`=15, `mem_rdy` held 0 in FETCH: `err`=1 on cycle 16 and sticky. Re-run with `mem_rdy` on wait-cycle 15: normal DECODE.
- HALT (00000): `halted`=1 from the cycle after DECODE, no further `mem_req`. Assert `rst_n`=0 mid-WB of a later run: `reg_write` drops asynchronously, state FETCH.
